// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add 5-bit multiplier that time-shares the ALU.
// Ports: CLK/RST, START/A/B in, BUSY/DONE/P/PZ out, ALU_A/B/OP out, ALU_R/ZF in.
module alu_mul_seq #(
    parameter int         WIDTH   = 5,
    parameter logic [1:0] IDLE_OP = 2'b11
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] P,
    output logic             PZ,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [1:0]       ALU_OP,
    input  logic [WIDTH-1:0] ALU_R,
    input  logic             ALU_ZF
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_ADD,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST = 3'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] tmp;
    logic [2:0]       i;
    logic             accept;

    assign BUSY = (state == S_SHIFT) || (state == S_ADD);
    assign DONE = (state == S_DONE);

    always_comb begin
        state_nx = state;
        ALU_A    = '0;
        ALU_B    = '0;
        ALU_OP   = IDLE_OP;
        accept   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (START) begin
                    accept   = 1'b1;
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                ALU_A    = mcand;
                ALU_B    = WIDTH'(i);
                ALU_OP   = 2'b10;
                state_nx = S_ADD;
            end
            S_ADD: begin
                ALU_A    = acc;
                ALU_B    = mplier[i] ? tmp : '0;
                ALU_OP   = 2'b00;
                state_nx = (i == LAST) ? S_DONE : S_SHIFT;
            end
            S_DONE: begin
                // a START here chains straight into the next run
                if (START) begin
                    accept   = 1'b1;
                    state_nx = S_SHIFT;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            tmp    <= '0;
            i      <= '0;
            P      <= '0;
            PZ     <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                mcand  <= A;
                mplier <= B;
                acc    <= '0;
                i      <= '0;
            end
            if (state == S_SHIFT) begin
                tmp <= ALU_R;
            end
            if (state == S_ADD) begin
                acc <= ALU_R;
                if (i == LAST) begin
                    P  <= ALU_R;
                    PZ <= ALU_ZF;
                end else begin
                    i <= i + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: randomized and directed bench for alu_mul_seq.
// Provides the shared ALU and a product-mod-32 reference model.
module tb_alu_mul_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [4:0] A;
    logic [4:0] B;
    logic       BUSY;
    logic       DONE;
    logic [4:0] P;
    logic       PZ;
    logic [4:0] ALU_A;
    logic [4:0] ALU_B;
    logic [1:0] ALU_OP;
    logic [4:0] alu_r;
    logic       alu_zf;

    int checks   = 0;
    int failures = 0;

    alu_mul_seq #(.WIDTH(5), .IDLE_OP(2'b11)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .A      (A),
        .B      (B),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .P      (P),
        .PZ     (PZ),
        .ALU_A  (ALU_A),
        .ALU_B  (ALU_B),
        .ALU_OP (ALU_OP),
        .ALU_R  (alu_r),
        .ALU_ZF (alu_zf)
    );

    always #5 CLK = ~CLK;

    // the external 5-bit ALU
    always_comb begin
        case (ALU_OP)
            2'b00:   alu_r = ALU_A + ALU_B;
            2'b10:   alu_r = ALU_A << ALU_B;
            default: alu_r = 5'd0;
        endcase
        alu_zf = (alu_r == 5'd0);
    end

    function automatic logic [4:0] ref_mul(input int a, input int b);
        return 5'((a * b) % 32);
    endfunction

    // start one multiply and watch it to completion (or timeout)
    task automatic run_mul(input logic [4:0] a, input logic [4:0] b,
                           output int nbusy, output int done_at,
                           output logic [4:0] p, output logic pz,
                           output logic [19:0] ops);
        @(negedge CLK);
        A = a;
        B = b;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        nbusy = 0;
        done_at = 0;
        p = 5'd0;
        pz = 1'b0;
        ops = '0;
        for (int k = 1; k <= 20; k++) begin
            if (BUSY) begin
                if (k <= 10) ops[2*(k-1) +: 2] = ALU_OP;
                nbusy++;
            end
            if (DONE) begin
                done_at = k;
                p = P;
                pz = PZ;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        START = 1'b0;
        A = 5'd0;
        B = 5'd0;
        #12;
        checks++;
        if ({BUSY, DONE, P, PZ} !== 8'd0) begin
            failures++;
            $display("FAIL reset_outs got %b want 0", {BUSY, DONE, P, PZ});
        end
        checks++;
        if ({ALU_OP, ALU_A, ALU_B} !== {2'b11, 10'd0}) begin
            failures++;
            $display("FAIL reset_alu got op=%b a=%0d b=%0d want op=11 a=0 b=0",
                     ALU_OP, ALU_A, ALU_B);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_basic();
        int nb, da;
        logic [4:0] p;
        logic pz;
        logic [19:0] ops, exp_ops;
        for (int j = 0; j < 10; j++)
            exp_ops[2*j +: 2] = (j % 2 == 0) ? 2'b10 : 2'b00;
        run_mul(5'd3, 5'd5, nb, da, p, pz, ops);
        checks++;
        if (nb != 10) begin
            failures++;
            $display("FAIL basic_busy got %0d want 10", nb);
        end
        checks++;
        if (da != 11) begin
            failures++;
            $display("FAIL basic_done_at got %0d want 11", da);
        end
        checks++;
        if (ops !== exp_ops) begin
            failures++;
            $display("FAIL basic_ops got %h want %h", ops, exp_ops);
        end
        checks++;
        if (p !== 5'd15 || pz !== 1'b0) begin
            failures++;
            $display("FAIL basic_p got %0d/%b want 15/0", p, pz);
        end
        checks++;
        if (ALU_OP !== 2'b11) begin
            failures++;
            $display("FAIL basic_done_op got %b want 11", ALU_OP);
        end
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || P !== 5'd15) begin
            failures++;
            $display("FAIL basic_after got done=%b busy=%b p=%0d want 0 0 15",
                     DONE, BUSY, P);
        end
    endtask

    task automatic test_products();
        logic [4:0] ta [5] = '{5'd7, 5'd31, 5'd8, 5'd0, 5'd13};
        logic [4:0] tb [5] = '{5'd9, 5'd31, 5'd4, 5'd22, 5'd0};
        for (int n = 0; n < 25; n++) begin
            int nb, da;
            logic [4:0] a, b, p, e;
            logic pz;
            logic [19:0] ops;
            if (n < 5) begin
                a = ta[n];
                b = tb[n];
            end else begin
                a = 5'($urandom_range(0, 31));
                b = 5'($urandom_range(0, 31));
            end
            e = ref_mul(int'(a), int'(b));
            run_mul(a, b, nb, da, p, pz, ops);
            checks++;
            if (p !== e || pz !== (e == 5'd0) || nb != 10 || da != 11) begin
                failures++;
                $display("FAIL prod_%0dx%0d got p=%0d pz=%b busy=%0d done=%0d want %0d %b 10 11",
                         a, b, p, pz, nb, da, e, (e == 5'd0));
            end
        end
    endtask

    task automatic test_ignore();
        int da = 0;
        @(negedge CLK);
        A = 5'd3;
        B = 5'd5;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 4) begin
                START = 1'b1;
                A = 5'd2;
                B = 5'd2;
            end
            if (k == 5) START = 1'b0;
            if (DONE) begin
                da = k;
                break;
            end
            @(negedge CLK);
        end
        checks++;
        if (da != 11 || P !== 5'd15) begin
            failures++;
            $display("FAIL ignore got done_at=%0d p=%0d want 11 15", da, P);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        @(negedge CLK);
        A = 5'd2;
        B = 5'd3;
        START = 1'b1;
        @(negedge CLK);
        for (int k = 1; k <= 33; k++) begin
            logic ed;
            ed = (k % 11 == 0);
            checks++;
            if (DONE !== ed || BUSY !== !ed) begin
                failures++;
                $display("FAIL b2b_cycle%0d got done=%b busy=%b want %b %b",
                         k, DONE, BUSY, ed, !ed);
            end
            if (ed) begin
                checks++;
                if (P !== 5'd6 || ALU_OP !== 2'b11) begin
                    failures++;
                    $display("FAIL b2b_done%0d got p=%0d op=%b want 6 11",
                             k, P, ALU_OP);
                end
            end
            @(negedge CLK);
        end
        START = 1'b0;
        repeat (12) @(negedge CLK);
        if (bad != 0) failures++;
    endtask

    task automatic test_async_reset();
        int nb, da;
        logic [4:0] p;
        logic pz;
        logic [19:0] ops;
        @(negedge CLK);
        A = 5'd3;
        B = 5'd5;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({BUSY, DONE, P, PZ} !== 8'd0 || ALU_OP !== 2'b11) begin
            failures++;
            $display("FAIL async_rst got busy=%b done=%b p=%0d pz=%b op=%b want 0 0 0 0 11",
                     BUSY, DONE, P, PZ, ALU_OP);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        run_mul(5'd5, 5'd5, nb, da, p, pz, ops);
        checks++;
        if (p !== 5'd25 || pz !== 1'b0 || da != 11 || nb != 10) begin
            failures++;
            $display("FAIL post_rst got p=%0d pz=%b done=%0d busy=%0d want 25 0 11 10",
                     p, pz, da, nb);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_products();
        test_ignore();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle sequencer that computes a 5-bit unsigned product (mod 32) on the shared 5-bit ALU using shift-and-add. It drives the ALU's A/B/OP inputs and captures its result each cycle. It sits between the CPU control unit, which issues START/DONE requests, and the ALU instance, so the datapath needs no dedicated multiplier. Latency is fixed and data-independent to simplify control-unit timing.

Parameters:
WIDTH, 5, operand/result width; must equal the ALU width (only 5 is supported, since the SHL amount uses ALU_B).
IDLE_OP, 2'b11, ALU opcode driven when not busy (11 = ALU outputs zero).

Ports:
CLK  in  1  system clock, rising-edge
RST  in  1  asynchronous, active-high reset
START  in  1  request pulse/level; sampled only in IDLE or DONE
A  in  5  multiplicand, captured on START acceptance
B  in  5  multiplier, captured on START acceptance
BUSY  out  1  high while the sequence is running
DONE  out  1  one-cycle pulse when P is valid
P  out  5  product mod 32; held until next accepted START
PZ  out  1  product-zero flag (from ALU ZF on final ADD); held with P
ALU_A  out  5  to ALU A
ALU_B  out  5  to ALU B
ALU_OP  out  2  to ALU OP (00 ADD, 10 SHL, IDLE_OP otherwise)
ALU_R  in  5  ALU result (combinational, same cycle)
ALU_ZF  in  1  ALU zero flag (combinational, same cycle)

Behaviour:
- One clock; reset is asynchronous and active-high. Clock port is CLK, reset port is RST.
- Reset (any time, including mid-sequence): state=IDLE; BUSY=0, DONE=0, P=0, PZ=0; internal mcand, mplier, acc, tmp, and bit index i are all 0. The in-flight operation is discarded.
- States:
  - IDLE: ALU_A=0, ALU_B=0, ALU_OP=IDLE_OP.
  - SHIFT: ALU_A=mcand, ALU_B=i, ALU_OP=10; tmp<=ALU_R at the clock edge.
  - ADD: ALU_A=acc, ALU_B=(mplier[i] ? tmp : 0), ALU_OP=00; acc<=ALU_R at the clock edge.
  - DONE: ALU outputs as in IDLE.
- Transitions:
  - IDLE/DONE + START=1: latch mcand=A, mplier=B; set acc=0, i=0; go to SHIFT.
  - IDLE + START=0: stay in IDLE.
  - DONE + START=0: go to IDLE.
  - SHIFT: always go to ADD.
  - ADD with i<4: i<=i+1; go to SHIFT.
  - ADD with i=4: P<=ALU_R, PZ<=ALU_ZF; go to DONE.
- Timing: START accepted at edge T gives BUSY=1 for cycles T+1..T+10 (5 × SHIFT/ADD pairs). DONE=1 during cycle T+11 only, with P/PZ valid from T+11.
- BUSY=1 exactly in SHIFT/ADD. START is ignored while BUSY=1, and A/B changes then have no effect.
- Back-to-back: START high in the DONE cycle is accepted, and the next sequence begins with no IDLE gap. P/PZ keep the old result until the new final ADD.
- Arithmetic: every ADD wraps mod 32 (the ALU has no carry-out), so P = (A*B) mod 32 exactly. SHL amounts are 0..4 and never exceed the width.
- DONE and BUSY are never high together. Outputs are registered, except ALU_A/ALU_B/ALU_OP, which decode from state and registers.

Test Plan:
- Reset, then A=3, B=5, START 1 cycle -> BUSY high for 10 cycles; ALU_OP sequence 10,00 ×5; DONE pulse at T+11; P=15, PZ=0.
- A=7, B=9 -> P=31 (63 mod 32), PZ=0. A=31, B=31 -> P=1. A=8, B=4 -> P=0, PZ=1 (wrap to zero).
- A=0, B=22 and A=13, B=0 -> P=0, PZ=1; still 10 busy cycles (fixed latency).
- START with A=3, B=5, then START with A=2, B=2 at cycle T+4 -> ignored; DONE at T+11 with P=15.
- START held high continuously with A=2, B=3 -> DONE every 11 cycles, no IDLE between runs, P=6 each time; in the DONE cycle, ALU_OP=IDLE_OP.
- Assert RST at T+6 (asynchronous, mid-clock) -> BUSY, DONE, P, and PZ drop to 0 immediately; ALU_OP=11. After release, START with A=5, B=5 -> P=25 after normal latency.
